sap_ram_controller: RTL and testbench
=====================================

Name: sap_ram_controller

Overview:
- Drives the address, data and control pins of the 16-word RAM built from SN74189 chips (4 bits per chip, outputs inverted).
- Program mode: accepts address/data words over a valid/ready handshake and sequences the RAM write pulse with setup and hold cycles.
- Run mode: acts as the SAP memory address register (MAR). It loads the address from the bus and puts the re-inverted RAM word on the bus.

Parameters:
- ADDR_W, 4, RAM address width (16 words).
- DATA_W, 8, word width (two 4-bit RAM chips side by side).

Ports:
- CLK  input  1  system clock; every register updates on the rising edge.
- CLR  input  1  reset, synchronous, active-high.
- PROG  input  1  1 = program mode, 0 = run mode.
- PRG_VALID  input  1  loader offers a word.
- PRG_READY  output  1  controller can accept a word.
- PRG_ADDR  input  ADDR_W  target address of the offered word.
- PRG_DATA  input  DATA_W  true-polarity data of the offered word.
- PRG_ERR  output  1  sticky verify-mismatch flag (only with RAM_VERIFY_EN).
- LM_bar  input  1  active-low "load MAR from bus".
- CE_bar  input  1  active-low "RAM drives bus".
- BUS_IN  input  ADDR_W  low bits of the W bus, used as the MAR source.
- BUS_OUT  output  DATA_W  RAM word to the bus, true polarity.
- BUS_OE  output  1  BUS_OUT is valid and driving.
- RAM_A  output  ADDR_W  RAM address pins.
- RAM_DI  output  DATA_W  RAM data-in pins.
- RAM_DO  input  DATA_W  raw RAM outputs: active-low; Z when deselected or writing.
- RAM_S_bar  output  1  RAM select, active-low.
- RAM_W_bar  output  1  RAM write enable, active-low.

Behaviour:
- Reset values (cycle after CLR=1):
  - MAR=0, state=IDLE, PRG_READY=0, PRG_ERR=0.
  - RAM_S_bar=1, RAM_W_bar=1, RAM_A=0, RAM_DI=0.
  - BUS_OE=0, BUS_OUT=0.
- CLR asserted mid-write: the sequence is aborted at the next edge (RAM_W_bar=1, RAM_S_bar=1). Contents at the in-flight address are undefined.
- FSM states:
  - IDLE: PRG_READY = PROG.
  - Handshake: a word transfers on a rising edge where PRG_VALID=1 and PRG_READY=1. PRG_ADDR and PRG_DATA are latched into internal registers, and the state moves to W_SETUP.
  - W_SETUP: RAM_A and RAM_DI come from the latches; RAM_S_bar=0, RAM_W_bar=1. Next state W_PULSE.
  - W_PULSE: same RAM_A/RAM_DI; RAM_S_bar=0, RAM_W_bar=0. Next state W_HOLD.
  - W_HOLD: same RAM_A/RAM_DI; RAM_S_bar=0, RAM_W_bar=1. Next state IDLE, or V_READ when the verify feature is compiled in.
- PRG_READY is 0 in every state other than IDLE. Write throughput is therefore one word per 4 cycles, or 5 with verify.
- RAM_A and RAM_DI never change while RAM_W_bar=0.
- RAM_DI = PRG_DATA latch, uninverted (the chips store true data and output the complement).
- PROG falling during W_SETUP, W_PULSE, W_HOLD or V_READ: the sequence completes, then the controller enters run behaviour. A write is never truncated by a mode change.
- Run mode (PROG=0, state=IDLE):
  - RAM_A = MAR.
  - LM_bar=0 at a rising edge: MAR <= BUS_IN.
  - CE_bar=0: RAM_S_bar=0, RAM_W_bar=1, BUS_OE=1, BUS_OUT = ~RAM_DO. Combinational; data is valid in the same cycle.
  - CE_bar=1: RAM_S_bar=1, BUS_OE=0, BUS_OUT=0.
- Run-mode edge cases:
  - LM_bar=0 and CE_bar=0 in the same cycle: the bus carries the word at the old MAR. MAR updates at the edge.
- Program-mode edge cases:
  - LM_bar and CE_bar are ignored in program mode and in all non-IDLE states.
  - BUS_OE=0 in program mode.
  - MAR holds its value through program mode.
- Address width: MAR and RAM_A are ADDR_W bits with no wrap logic. Address 15 is an ordinary address.

Optional Feature:
- Macro: RAM_VERIFY_EN.
- When defined:
  - W_HOLD goes to V_READ instead of IDLE.
  - V_READ: RAM_A = latched address, RAM_S_bar=0, RAM_W_bar=1.
  - At the end of V_READ, ~RAM_DO is compared with the data latch. A mismatch sets PRG_ERR=1, which stays set until CLR.
  - Next state IDLE.
- When undefined:
  - No V_READ state; PRG_ERR is constant 0.
  - Write sequence is 3 cycles after acceptance.

Test Plan:
- Reset: hold CLR=1 two cycles with PROG=1 -> RAM_S_bar=1, RAM_W_bar=1, PRG_READY=0, BUS_OE=0, MAR=0. PRG_READY=1 in the first cycle after CLR falls.
- Program 16 words, data=(k+5)%16 at address k, PRG_VALID held high -> one acceptance every 4 cycles (5 with RAM_VERIFY_EN). Exactly one RAM_W_bar low cycle per word, with RAM_A/RAM_DI stable from W_SETUP through W_HOLD.
- Run read: PROG=0, BUS_IN=7, LM_bar=0 for one edge, then CE_bar=0 -> RAM_A=7, BUS_OE=1, BUS_OUT=12 in the same cycle.
- Simultaneous LM/CE: MAR=3, BUS_IN=9, LM_bar=0 and CE_bar=0 together -> BUS_OUT=8 that cycle, then BUS_OUT=14 the next cycle with only CE_bar=0.
- Mode change and reset mid-write:
  - PROG dropped during W_PULSE -> W_HOLD still occurs and address written correctly; run reads begin after return to IDLE.
  - CLR during W_PULSE -> RAM_W_bar=1 and RAM_S_bar=1 on the next edge.
- Verify (RAM_VERIFY_EN): RAM model with a stuck-at-1 bit 0 at address 2; write 0x00 to address 2 -> PRG_ERR=1 after V_READ. PRG_ERR stays 1 across later good writes and clears only on CLR.

Source files
------------

// File: rtl/sap_ram_controller.sv
// rtl/sap_ram_controller.sv - SAP RAM controller: program-mode write sequencer and run-mode MAR/read path
//
// Drives a 16-word RAM built from inverting-output SN74189 chips.
// Program mode (PROG=1): accepts address/data words on a valid/ready handshake
//   and sequences setup / write pulse / hold cycles on the RAM pins.
// Run mode (PROG=0, idle): holds the memory address register (MAR), loaded from
//   BUS_IN on LM_bar, and drives the re-inverted RAM word onto the bus on CE_bar.
// Optional: define RAM_VERIFY_EN to add a read-back cycle after each write that
//   sets the sticky PRG_ERR flag on a mismatch.
//
// Ports:
//   CLK, CLR              clock, synchronous active-high reset
//   PROG                  1 = program mode, 0 = run mode
//   PRG_VALID/PRG_READY   loader handshake; PRG_ADDR/PRG_DATA are the offered word
//   PRG_ERR               sticky verify-mismatch flag (0 without RAM_VERIFY_EN)
//   LM_bar, CE_bar        active-low load-MAR and RAM-to-bus controls
//   BUS_IN                MAR source (low bits of the W bus)
//   BUS_OUT, BUS_OE       true-polarity RAM word and its drive enable
//   RAM_A, RAM_DI         RAM address and data-in pins
//   RAM_DO                raw (complemented) RAM outputs
//   RAM_S_bar, RAM_W_bar  RAM select and write enable, active-low

module sap_ram_controller #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              PROG,
    input  logic              PRG_VALID,
    output logic              PRG_READY,
    input  logic [ADDR_W-1:0] PRG_ADDR,
    input  logic [DATA_W-1:0] PRG_DATA,
    output logic              PRG_ERR,
    input  logic              LM_bar,
    input  logic              CE_bar,
    input  logic [ADDR_W-1:0] BUS_IN,
    output logic [DATA_W-1:0] BUS_OUT,
    output logic              BUS_OE,
    output logic [ADDR_W-1:0] RAM_A,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO,
    output logic              RAM_S_bar,
    output logic              RAM_W_bar
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD
`ifdef RAM_VERIFY_EN
        , V_READ
`endif
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              run_idle;

    assign accept   = PRG_VALID && PRG_READY;
    assign run_idle = (state == IDLE) && !PROG;

    // State register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: once a word is accepted the sequence runs to completion
    // regardless of PROG, so a mode change never truncates a write.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = W_SETUP;
            W_SETUP: next_state = W_PULSE;
            W_PULSE: next_state = W_HOLD;
`ifdef RAM_VERIFY_EN
            W_HOLD:  next_state = V_READ;
            V_READ:  next_state = IDLE;
`else
            W_HOLD:  next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Output logic. PRG_READY is masked by CLR so no word is offered while the
    // controller is held in reset.
    always_comb begin
        PRG_READY = 1'b0;
        RAM_S_bar = 1'b1;
        RAM_W_bar = 1'b1;
        RAM_A     = addr_q;
        BUS_OE    = 1'b0;
        BUS_OUT   = '0;
        case (state)
            IDLE: begin
                RAM_A = mar;
                if (!CLR) begin
                    PRG_READY = PROG;
                    if (!PROG && !CE_bar) begin
                        RAM_S_bar = 1'b0;
                        BUS_OE    = 1'b1;
                        BUS_OUT   = ~RAM_DO;
                    end
                end
            end
            W_SETUP, W_HOLD: RAM_S_bar = 1'b0;
            W_PULSE: begin
                RAM_S_bar = 1'b0;
                RAM_W_bar = 1'b0;
            end
`ifdef RAM_VERIFY_EN
            V_READ:  RAM_S_bar = 1'b0;
`endif
            default: ;
        endcase
    end

    // The chips store true data and output its complement, so data-in is
    // driven uninverted. The latch only changes on acceptance, which keeps
    // RAM_A/RAM_DI stable across the whole write sequence.
    assign RAM_DI = data_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            mar    <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= PRG_ADDR;
                data_q <= PRG_DATA;
            end
            if (run_idle && !LM_bar) begin
                mar <= BUS_IN;
            end
        end
    end

`ifdef RAM_VERIFY_EN
    logic prg_err_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            prg_err_q <= 1'b0;
        end else if ((state == V_READ) && ((~RAM_DO) != data_q)) begin
            prg_err_q <= 1'b1;
        end
    end

    assign PRG_ERR = prg_err_q;
`else
    assign PRG_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sap_ram_controller.sv
// tb/tb_sap_ram_controller.sv - directed self-checking bench for sap_ram_controller

module tb_sap_ram_controller;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
`ifdef RAM_VERIFY_EN
    localparam int SEQ     = 4;
    localparam logic ERR_EXP = 1'b1;
`else
    localparam int SEQ     = 3;
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              CLR;
    logic              PROG;
    logic              PRG_VALID;
    logic              PRG_READY;
    logic [ADDR_W-1:0] PRG_ADDR;
    logic [DATA_W-1:0] PRG_DATA;
    logic              PRG_ERR;
    logic              LM_bar;
    logic              CE_bar;
    logic [ADDR_W-1:0] BUS_IN;
    logic [DATA_W-1:0] BUS_OUT;
    logic              BUS_OE;
    logic [ADDR_W-1:0] RAM_A;
    logic [DATA_W-1:0] RAM_DI;
    logic [DATA_W-1:0] RAM_DO;
    logic              RAM_S_bar;
    logic              RAM_W_bar;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    sap_ram_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .CLR(CLR), .PROG(PROG),
        .PRG_VALID(PRG_VALID), .PRG_READY(PRG_READY),
        .PRG_ADDR(PRG_ADDR), .PRG_DATA(PRG_DATA), .PRG_ERR(PRG_ERR),
        .LM_bar(LM_bar), .CE_bar(CE_bar), .BUS_IN(BUS_IN),
        .BUS_OUT(BUS_OUT), .BUS_OE(BUS_OE),
        .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO),
        .RAM_S_bar(RAM_S_bar), .RAM_W_bar(RAM_W_bar)
    );

    // RAM model: stores true data, outputs complement; bit 0 of address 2 is stuck at 1.
    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] rd_word;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
    end

    always @(posedge CLK) begin
        if (!RAM_S_bar && !RAM_W_bar) mem[RAM_A] <= RAM_DI;
    end

    assign rd_word = mem[RAM_A] | ((RAM_A == 4'd2) ? 8'h01 : 8'h00);
    assign RAM_DO  = (!RAM_S_bar && RAM_W_bar) ? ~rd_word : 8'hFF;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b1; PROG = 1'b1; PRG_VALID = 1'b0; PRG_ADDR = '0; PRG_DATA = '0;
        LM_bar = 1'b1; CE_bar = 1'b1; BUS_IN = '0;
        step();
        step();
        checks++; if (RAM_S_bar !== 1'b1) begin errors++; $display("FAIL reset_s_bar: got %b expected 1", RAM_S_bar); end
        checks++; if (RAM_W_bar !== 1'b1) begin errors++; $display("FAIL reset_w_bar: got %b expected 1", RAM_W_bar); end
        checks++; if (PRG_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", PRG_READY); end
        checks++; if (BUS_OE !== 1'b0) begin errors++; $display("FAIL reset_bus_oe: got %b expected 0", BUS_OE); end
        checks++; if (BUS_OUT !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h expected 00", BUS_OUT); end
        checks++; if (RAM_A !== 4'h0) begin errors++; $display("FAIL reset_mar: got %h expected 0", RAM_A); end
        checks++; if (RAM_DI !== 8'h00) begin errors++; $display("FAIL reset_ram_di: got %h expected 00", RAM_DI); end
        checks++; if (PRG_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", PRG_ERR); end
        CLR = 1'b0;
        #1;
        checks++; if (PRG_READY !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", PRG_READY); end
    endtask

    task automatic test_program();
        int wlow;
        logic [DATA_W-1:0] d;
        PROG = 1'b1;
        PRG_VALID = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d = DATA_W'((k + 5) % 16);
            PRG_ADDR = ADDR_W'(k);
            PRG_DATA = d;
            #1;
            checks++; if (PRG_READY !== 1'b1) begin errors++; $display("FAIL prog_ready k=%0d: got %b expected 1", k, PRG_READY); end
            step();
            wlow = 0;
            for (int c = 0; c < SEQ; c++) begin
                checks++;
                if (RAM_A !== ADDR_W'(k) || RAM_DI !== d || RAM_S_bar !== 1'b0 || PRG_READY !== 1'b0) begin
                    errors++;
                    $display("FAIL prog_seq k=%0d c=%0d: got A=%h DI=%h S=%b RDY=%b expected A=%h DI=%h S=0 RDY=0",
                             k, c, RAM_A, RAM_DI, RAM_S_bar, PRG_READY, k, d);
                end
                if (RAM_W_bar === 1'b0) wlow++;
                checks++;
                if (RAM_W_bar !== ((c == 1) ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("FAIL prog_wbar k=%0d c=%0d: got %b expected %b", k, c, RAM_W_bar, (c == 1) ? 1'b0 : 1'b1);
                end
                step();
            end
            checks++; if (wlow !== 1) begin errors++; $display("FAIL prog_pulses k=%0d: got %0d expected 1", k, wlow); end
        end
        PRG_VALID = 1'b0;
    endtask

    task automatic test_run_read();
        PROG = 1'b0;
        BUS_IN = 4'd7;
        LM_bar = 1'b0;
        step();
        LM_bar = 1'b1;
        CE_bar = 1'b0;
        #1;
        checks++; if (RAM_A !== 4'd7) begin errors++; $display("FAIL run_ram_a: got %h expected 7", RAM_A); end
        checks++; if (BUS_OE !== 1'b1) begin errors++; $display("FAIL run_bus_oe: got %b expected 1", BUS_OE); end
        checks++; if (BUS_OUT !== 8'd12) begin errors++; $display("FAIL run_bus_out: got %0d expected 12", BUS_OUT); end
        checks++; if (RAM_S_bar !== 1'b0) begin errors++; $display("FAIL run_s_bar: got %b expected 0", RAM_S_bar); end
        CE_bar = 1'b1;
        #1;
        checks++; if (BUS_OE !== 1'b0 || BUS_OUT !== 8'h00 || RAM_S_bar !== 1'b1) begin
            errors++; $display("FAIL run_ce_off: got OE=%b OUT=%h S=%b expected OE=0 OUT=00 S=1", BUS_OE, BUS_OUT, RAM_S_bar);
        end
    endtask

    task automatic test_simultaneous();
        BUS_IN = 4'd3;
        LM_bar = 1'b0;
        step();
        BUS_IN = 4'd9;
        CE_bar = 1'b0;
        #1;
        checks++; if (BUS_OUT !== 8'd8) begin errors++; $display("FAIL simul_old_mar: got %0d expected 8", BUS_OUT); end
        step();
        LM_bar = 1'b1;
        #1;
        checks++; if (BUS_OUT !== 8'd14) begin errors++; $display("FAIL simul_new_mar: got %0d expected 14", BUS_OUT); end
        checks++; if (RAM_A !== 4'd9) begin errors++; $display("FAIL simul_ram_a: got %h expected 9", RAM_A); end
        CE_bar = 1'b1;
    endtask

    task automatic test_prog_mode_ignore();
        PROG = 1'b1;
        BUS_IN = 4'd5;
        LM_bar = 1'b0;
        CE_bar = 1'b0;
        #1;
        checks++; if (BUS_OE !== 1'b0 || RAM_S_bar !== 1'b1) begin
            errors++; $display("FAIL prog_ignore_ce: got OE=%b S=%b expected OE=0 S=1", BUS_OE, RAM_S_bar);
        end
        step();
        LM_bar = 1'b1;
        PROG = 1'b0;
        #1;
        checks++; if (RAM_A !== 4'd9 || BUS_OUT !== 8'd14) begin
            errors++; $display("FAIL prog_ignore_lm: got A=%h OUT=%0d expected A=9 OUT=14", RAM_A, BUS_OUT);
        end
        CE_bar = 1'b1;
    endtask

    task automatic test_mode_change();
        PROG = 1'b1;
        PRG_ADDR = 4'd4;
        PRG_DATA = 8'hA5;
        PRG_VALID = 1'b1;
        #1;
        step();
        PRG_VALID = 1'b0;
        step();
        checks++; if (RAM_W_bar !== 1'b0) begin errors++; $display("FAIL mode_pulse: got %b expected 0", RAM_W_bar); end
        PROG = 1'b0;
        CE_bar = 1'b0;
        step();
        checks++; if (RAM_W_bar !== 1'b1 || RAM_S_bar !== 1'b0 || RAM_A !== 4'd4 || BUS_OE !== 1'b0) begin
            errors++; $display("FAIL mode_hold: got W=%b S=%b A=%h OE=%b expected W=1 S=0 A=4 OE=0", RAM_W_bar, RAM_S_bar, RAM_A, BUS_OE);
        end
        for (int i = 0; i < SEQ - 2; i++) step();
        checks++; if (BUS_OE !== 1'b1 || BUS_OUT !== 8'd14) begin
            errors++; $display("FAIL mode_run_resume: got OE=%b OUT=%0d expected OE=1 OUT=14", BUS_OE, BUS_OUT);
        end
        CE_bar = 1'b1;
        BUS_IN = 4'd4;
        LM_bar = 1'b0;
        step();
        LM_bar = 1'b1;
        CE_bar = 1'b0;
        #1;
        checks++; if (BUS_OUT !== 8'hA5) begin errors++; $display("FAIL mode_written: got %h expected a5", BUS_OUT); end
        CE_bar = 1'b1;
    endtask

    task automatic test_clr_mid_write();
        PROG = 1'b1;
        PRG_ADDR = 4'd6;
        PRG_DATA = 8'h33;
        PRG_VALID = 1'b1;
        #1;
        step();
        PRG_VALID = 1'b0;
        step();
        checks++; if (RAM_W_bar !== 1'b0) begin errors++; $display("FAIL clr_pulse: got %b expected 0", RAM_W_bar); end
        CLR = 1'b1;
        step();
        checks++; if (RAM_W_bar !== 1'b1 || RAM_S_bar !== 1'b1 || PRG_READY !== 1'b0) begin
            errors++; $display("FAIL clr_abort: got W=%b S=%b RDY=%b expected W=1 S=1 RDY=0", RAM_W_bar, RAM_S_bar, PRG_READY);
        end
        CLR = 1'b0;
        #1;
        checks++; if (PRG_READY !== 1'b1 || RAM_A !== 4'd0) begin
            errors++; $display("FAIL clr_recover: got RDY=%b A=%h expected RDY=1 A=0", PRG_READY, RAM_A);
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        PROG = 1'b1;
        PRG_ADDR = a;
        PRG_DATA = d;
        PRG_VALID = 1'b1;
        #1;
        n = 0;
        while (PRG_READY !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            errors++; checks++;
            $display("FAIL write_word_timeout: got ready=%b expected 1", PRG_READY);
        end
        step();
        PRG_VALID = 1'b0;
        for (int i = 0; i < SEQ; i++) step();
    endtask

    task automatic test_verify();
        write_word(4'd2, 8'h00);
        checks++; if (PRG_ERR !== ERR_EXP) begin errors++; $display("FAIL verify_set: got %b expected %b", PRG_ERR, ERR_EXP); end
        write_word(4'd3, 8'h55);
        checks++; if (PRG_ERR !== ERR_EXP) begin errors++; $display("FAIL verify_sticky: got %b expected %b", PRG_ERR, ERR_EXP); end
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        #1;
        checks++; if (PRG_ERR !== 1'b0) begin errors++; $display("FAIL verify_clear: got %b expected 0", PRG_ERR); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_program();
        test_run_read();
        test_simultaneous();
        test_prog_mode_ignore();
        test_mode_change();
        test_clr_mid_write();
        test_verify();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
